// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and helpers for the instruction-memory responder.
// Contents:
//   imem_state_t           LOAD (preload via load port) / RUN (serve fetches)
//   rd_req_t               one read-pipeline entry: word index, range flag, RUN-valid flag
//   IMEM_FILL_WORD_DEFAULT NOP returned for out-of-range or invalid responses
//   even_parity()          parity bit stored alongside each word (IMEM_PARITY_EN builds)
package imem_pkg;

    typedef enum logic {IMEM_LOAD, IMEM_RUN} imem_state_t;

    typedef struct packed {
        logic [29:0] idx;
        logic        in_range;
        logic        vld;
    } rd_req_t;

    localparam logic [31:0] IMEM_FILL_WORD_DEFAULT = 32'h0000_0013;

    function automatic logic even_parity(input logic [31:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/imem_rd_pipe.sv
// imem_rd_pipe: READ_LAT-stage delay line of read requests; only the vld bits are reset.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-high reset, clears every stage's vld
//   req  in   request entering the pipe this cycle
//   rsp  out  request presented READ_LAT cycles ago (same cycle when READ_LAT=0)
module imem_rd_pipe
    import imem_pkg::*;
#(
    parameter int READ_LAT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_req_t req,
    output rd_req_t rsp
);

    generate
        if (READ_LAT == 0) begin : g_pass
            logic unused;
            assign unused = clk ^ rst;
            assign rsp = req;
        end else begin : g_pipe
            rd_req_t stg [READ_LAT];
            always_ff @(posedge clk) begin
                stg[0] <= req;
                for (int i = 1; i < READ_LAT; i++) stg[i] <= stg[i-1];
                if (rst) for (int i = 0; i < READ_LAT; i++) stg[i].vld <= 1'b0;
            end
            assign rsp = stg[READ_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/imem_responder.sv
// imem_responder: instruction-fetch responder with a LOAD-phase preload port and a
// READ_LAT-cycle read pipeline. Optional build macro: IMEM_PARITY_EN (per-word even parity).
// Ports:
//   clk, rst           clock; synchronous active-high reset (memory contents survive it)
//   proc2Imem_addr     fetch byte address, bits [1:0] ignored
//   Imem2proc_data     fetched word, FILL_WORD when invalid or out of range
//   Imem2proc_valid    response belongs to a request made in RUN
//   Imem2proc_oor      valid response whose address was out of range
//   Imem2proc_perr     parity mismatch on a valid in-range response (0 without IMEM_PARITY_EN)
//   load_valid/ready   load handshake, ready only in LOAD
//   load_addr/data     load byte address (bits [1:0] ignored) and word
//   run_go             LOAD->RUN request pulse
//   running            state is RUN
//   load_count         accepted in-range loads, saturating at DEPTH_WORDS
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          READ_LAT    = 1,
    parameter logic [31:0] FILL_WORD   = IMEM_FILL_WORD_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [31:0]                    proc2Imem_addr,
    output logic [31:0]                    Imem2proc_data,
    output logic                           Imem2proc_valid,
    output logic                           Imem2proc_oor,
    output logic                           Imem2proc_perr,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [31:0]                    load_addr,
    input  logic [31:0]                    load_data,
    input  logic                           run_go,
    output logic                           running,
    output logic [$clog2(DEPTH_WORDS):0]   load_count
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = AW + 1;

    imem_state_t state, state_nxt;
    logic [31:0] mem [DEPTH_WORDS];
    logic [29:0] load_idx;
    logic        load_we;
    rd_req_t     req, rsp;
    logic [31:0] word;
    logic        unused;

    always_ff @(posedge clk) state <= rst ? IMEM_LOAD : state_nxt;

    always_comb begin
        state_nxt = (state == IMEM_LOAD && run_go) ? IMEM_RUN : state;
    end

    assign load_ready = (state == IMEM_LOAD);
    assign running    = (state == IMEM_RUN);

    // Range checks use the full 30-bit index so high address bits never alias low words.
    assign load_idx = load_addr[31:2];
    assign load_we  = load_valid && load_ready && (32'(load_idx) < DEPTH_WORDS);

    always_ff @(posedge clk) if (load_we) mem[load_idx[AW-1:0]] <= load_data;

    always_ff @(posedge clk) begin
        if (rst) load_count <= '0;
        else if (load_we && load_count != CW'(DEPTH_WORDS)) load_count <= load_count + 1'b1;
    end

    assign req.idx      = proc2Imem_addr[31:2];
    assign req.in_range = 32'(proc2Imem_addr[31:2]) < DEPTH_WORDS;
    assign req.vld      = (state == IMEM_RUN);

    imem_rd_pipe #(.READ_LAT(READ_LAT)) u_pipe (
        .clk (clk),
        .rst (rst),
        .req (req),
        .rsp (rsp)
    );

    // Memory is only written in LOAD, where every response is invalid, so an
    // asynchronous read at the pipe output sees the same contents as at request time.
    assign word            = mem[rsp.idx[AW-1:0]];
    assign Imem2proc_valid = rsp.vld;
    assign Imem2proc_data  = (rsp.vld && rsp.in_range) ? word : FILL_WORD;
    assign Imem2proc_oor   = rsp.vld && !rsp.in_range;

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH_WORDS];
    always_ff @(posedge clk) if (load_we) mem_par[load_idx[AW-1:0]] <= even_parity(load_data);
    assign Imem2proc_perr = rsp.vld && rsp.in_range && (even_parity(word) != mem_par[rsp.idx[AW-1:0]]);
`else
    assign Imem2proc_perr = 1'b0;
`endif

    assign unused = ^{load_addr[1:0], proc2Imem_addr[1:0], rsp.idx[29:AW]};

endmodule
